jtag_ahb_dap: RTL and testbench
===============================

Name: jtag_ahb_dap

Overview:
Parametrised next-generation JTAG debug access port: an IEEE 1149.1 TAP controller plus an AHB-Lite single-master transfer engine. Data and address widths are generic. The block adds a status register, HRESP error capture, HREADY wait-state handling, busy/overrun detection and optional address auto-increment. It sits between the external JTAG pins and the system AHB-Lite fabric; the AHB side is clocked by TCK.

Parameters:
DATA_WIDTH, 32, AHB data width; legal values 8/16/32/64; also the READ/WRITE DR length.
ADDR_WIDTH, 32, HADDR width and ADDR DR length.
IR_SIZE, 4, instruction register length (minimum 3).
IDCODE_VAL, 32'h1000F00F, IDCODE DR content; bit0 must be 1.

Ports:
TCK  in  1  single clock; TAP and AHB engine both sample on the rising edge.
TRST  in  1  reset; synchronous, active-high.
TMS  in  1  TAP mode select.
TDI  in  1  serial data in, LSB first.
TDO  out  1  serial data out.
HADDR  out  ADDR_WIDTH  AHB address.
HTRANS  out  2  AHB transfer type; only IDLE (00) and NONSEQ (10) are used.
HWRITE  out  1  1 = write.
HSIZE  out  3  fixed at log2(DATA_WIDTH/8).
HWDATA  out  DATA_WIDTH  write data.
HRDATA  in  DATA_WIDTH  read data.
HREADY  in  1  transfer done / wait state.
HRESP  in  1  1 = error response.

Behaviour:
- Reset (TRST=1 at an edge): TAP goes to Test-Logic-Reset; IR=IDCODE; addr, wdata and rdata = 0; status = 0; engine to IDLE. After reset: TDO=0, HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0. TRST mid-transfer aborts: HTRANS=00 from the next cycle and busy=0.
- TAP FSM: all 16 standard states with standard TMS transitions. Five consecutive TMS=1 edges reach Test-Logic-Reset from any state. That state sets IR=IDCODE but does NOT abort an in-flight AHB transfer.
- IR: Capture-IR loads 'b...01. Shift-IR shifts LSB first. Update-IR latches the shift register into IR.
- Instructions: 0001 IDCODE (32-bit DR); 0010 AHB_ADDR (ADDR_WIDTH); 0011 AHB_WRITE (DATA_WIDTH); 0100 AHB_READ (DATA_WIDTH); 0101 STATUS (3 bits); all-ones and every unlisted code = BYPASS (1 bit, captures 0).
- TDO: equals shift-register bit0 while in Shift-IR or Shift-DR, otherwise 0. A DR shift presents the captured LSB first; each Shift edge moves TDI into the MSB.
- Capture-DR per instruction: IDCODE loads IDCODE_VAL; ADDR loads addr; WRITE loads wdata; READ loads rdata (result of the last completed read); STATUS loads {err, overrun, busy}.
- Update-DR, AHB_ADDR: addr <= shift value, with the low log2(DATA_WIDTH/8) bits forced to 0.
- Update-DR, AHB_WRITE: wdata <= shift value, then start a write. Update-DR, AHB_READ: start a read. The shifted value is ignored for READ.
- Update-DR, STATUS: each shifted 1 in bit2/bit1 clears err/overrun. Busy is read-only.
- Engine states: IDLE -> ADDR -> DATA -> IDLE.
  - Cycle N: TAP in Update-DR and start accepted.
  - N+1 (ADDR): HTRANS=NONSEQ, HADDR=addr, HWRITE set; state is held while HREADY=0.
  - Next cycle (DATA): HTRANS=00; HWDATA=wdata on writes, held stable through the data phase; the phase completes at the first edge with HREADY=1.
  - On completion: reads capture HRDATA into rdata; HRESP=1 sets sticky err (read data is still captured). Busy=1 from N+1 through completion and 0 the cycle after.
- Start requested while busy: ignored, no second NONSEQ, overrun <= 1 (sticky). wdata is not overwritten.
- Capture-DR of READ while busy loads the stale rdata. Software checks STATUS.

Optional Feature:
JTAG_AHB_AUTOINC_EN
- Defined: after each completed transfer with HRESP=0, addr <= addr + DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH. The increment is not applied on an error response.
- Undefined: addr changes only on AHB_ADDR Update-DR.

Test Plan:
1. Pulse TRST, then walk to Shift-DR and shift 32 bits -> TDO=0 and HTRANS=00 after reset; the shifted-out bits are 32'h1000F00F, LSB first.
2. Load IR=1111, then shift DR with TDI=10110011 -> TDO returns 0 followed by TDI delayed one cycle; IR capture reads 0001 in its low 2 bits.
3. ADDR=0x20000010, then WRITE 0xDEADBEEF with HREADY=1 -> one NONSEQ cycle with HADDR=0x20000010, HWRITE=1, HSIZE=010; next cycle HWDATA=0xDEADBEEF. With AUTOINC, the ADDR capture then reads 0x20000014; without it, 0x20000010.
4. READ with HREADY=0 for 3 cycles and HRDATA=0x0000F00F -> a single NONSEQ cycle and a 4-cycle data phase; the next READ DR scan shifts out 0x0000F00F; STATUS reads 000.
5. WRITE completing with HRESP=1 -> STATUS reads 100; shift 100 into STATUS -> a second scan reads 000; with AUTOINC, addr is unchanged.
6. Start READ with HREADY=0, then issue a WRITE Update-DR -> no second NONSEQ and STATUS reads 011. Assert TRST during the data phase -> HTRANS=00 and busy=0 on the next cycle.

Source files
------------

// File: rtl/jtag_ahb_dap_if.sv
// AHB-Lite single-master bus bundle for the JTAG debug access port.
// Ports: HADDR/HTRANS/HWRITE/HSIZE/HWDATA driven by the master;
//        HRDATA/HREADY/HRESP driven by the slave side.
interface jtag_ahb_dap_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/jtag_ahb_dap.sv
// JTAG debug access port: IEEE 1149.1 TAP plus an AHB-Lite single-transfer
// engine, both clocked by TCK.
// Ports: TCK clock; TRST synchronous active-high reset; TMS/TDI/TDO JTAG pins;
//        ahb (jtag_ahb_dap_if.master) AHB-Lite master bus.
// Optional macro JTAG_AHB_AUTOINC_EN: advance addr by one beat after each
// transfer that completes without an error response.
module jtag_ahb_dap #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IR_SIZE    = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000F00F
) (
  input  logic           TCK,
  input  logic           TRST,
  input  logic           TMS,
  input  logic           TDI,
  output logic           TDO,
  jtag_ahb_dap_if.master ahb
);
  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);
  localparam int unsigned DR_W0    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned DR_W     = (DR_W0 > 32) ? DR_W0 : 32;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

  localparam logic [IR_SIZE-1:0] IR_IDCODE = IR_SIZE'(1);
  localparam logic [IR_SIZE-1:0] IR_ADDR   = IR_SIZE'(2);
  localparam logic [IR_SIZE-1:0] IR_WRITE  = IR_SIZE'(3);
  localparam logic [IR_SIZE-1:0] IR_READ   = IR_SIZE'(4);
  localparam logic [IR_SIZE-1:0] IR_STATUS = IR_SIZE'(5);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR,
    TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR,
    TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
  } tap_t;

  typedef enum logic [1:0] {ENG_IDLE, ENG_ADDR, ENG_DATA} eng_t;

  tap_t                  r_tap, w_tap_nxt;
  eng_t                  r_eng, w_eng_nxt;
  logic [IR_SIZE-1:0]    r_ir, r_ir_sr, w_ir_sr_nxt;
  logic [DR_W-1:0]       r_dr, w_dr_nxt, w_dr_cap, w_dr_shift;
  logic [ADDR_WIDTH-1:0] r_addr, r_haddr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [1:0]            r_htrans;
  logic                  r_hwrite, r_err, r_ovr, r_tdo, w_tdo_nxt;
  logic                  w_busy, w_start, w_accept, w_done;
  int unsigned           w_dr_len;

  assign ahb.HADDR  = r_haddr;
  assign ahb.HTRANS = r_htrans;
  assign ahb.HWRITE = r_hwrite;
  assign ahb.HSIZE  = 3'(ADDR_LSB);
  assign ahb.HWDATA = r_wdata;
  assign TDO        = r_tdo;

  // TAP next-state: standard 1149.1 transition table
  always_comb begin
    w_tap_nxt = r_tap;
    case (r_tap)
      TAP_TLR:      w_tap_nxt = TMS ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      w_tap_nxt = TMS ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   w_tap_nxt = TMS ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   w_tap_nxt = TMS ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: w_tap_nxt = TMS ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: w_tap_nxt = TMS ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: w_tap_nxt = TMS ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: w_tap_nxt = TMS ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   w_tap_nxt = TMS ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   w_tap_nxt = TMS ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   w_tap_nxt = TMS ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: w_tap_nxt = TMS ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: w_tap_nxt = TMS ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: w_tap_nxt = TMS ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: w_tap_nxt = TMS ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   w_tap_nxt = TMS ? TAP_SEL_DR   : TAP_RTI;
      default:      w_tap_nxt = TAP_TLR;
    endcase
  end

  // AHB engine next-state; a start while busy is dropped and flagged as overrun
  always_comb begin
    w_eng_nxt = r_eng;
    w_busy    = (r_eng != ENG_IDLE);
    w_start   = (r_tap == TAP_UPD_DR) && ((r_ir == IR_WRITE) || (r_ir == IR_READ));
    w_accept  = w_start && !w_busy;
    w_done    = (r_eng == ENG_DATA) && ahb.HREADY;
    case (r_eng)
      ENG_IDLE: if (w_accept)   w_eng_nxt = ENG_ADDR;
      ENG_ADDR: if (ahb.HREADY) w_eng_nxt = ENG_DATA;
      ENG_DATA: if (ahb.HREADY) w_eng_nxt = ENG_IDLE;
      default:                  w_eng_nxt = ENG_IDLE;
    endcase
  end

  // DR/IR shift paths: TDI enters at the MSB of the selected register length
  always_comb begin
    w_dr_len = 1;
    w_dr_cap = '0;
    case (r_ir)
      IR_IDCODE: begin w_dr_len = 32;         w_dr_cap = DR_W'(IDCODE_VAL); end
      IR_ADDR:   begin w_dr_len = ADDR_WIDTH; w_dr_cap = DR_W'(r_addr);     end
      IR_WRITE:  begin w_dr_len = DATA_WIDTH; w_dr_cap = DR_W'(r_wdata);    end
      IR_READ:   begin w_dr_len = DATA_WIDTH; w_dr_cap = DR_W'(r_rdata);    end
      IR_STATUS: begin w_dr_len = 3;          w_dr_cap = DR_W'({r_err, r_ovr, w_busy}); end
      default:   begin w_dr_len = 1;          w_dr_cap = '0;                end
    endcase
    for (int unsigned i = 0; i < DR_W; i++) begin
      if (i + 1 == w_dr_len)     w_dr_shift[i] = TDI;
      else if (i + 1 < w_dr_len) w_dr_shift[i] = r_dr[i+1];
      else                       w_dr_shift[i] = 1'b0;
    end
    w_dr_nxt = r_dr;
    if (r_tap == TAP_CAP_DR)   w_dr_nxt = w_dr_cap;
    if (r_tap == TAP_SHIFT_DR) w_dr_nxt = w_dr_shift;
    w_ir_sr_nxt = r_ir_sr;
    if (r_tap == TAP_CAP_IR)   w_ir_sr_nxt = IR_SIZE'(1);
    if (r_tap == TAP_SHIFT_IR) w_ir_sr_nxt = {TDI, r_ir_sr[IR_SIZE-1:1]};
    w_tdo_nxt = 1'b0;
    if (w_tap_nxt == TAP_SHIFT_DR) w_tdo_nxt = w_dr_nxt[0];
    if (w_tap_nxt == TAP_SHIFT_IR) w_tdo_nxt = w_ir_sr_nxt[0];
  end

  // State and datapath registers
  always_ff @(posedge TCK) begin
    if (TRST) begin
      r_tap    <= TAP_TLR;
      r_eng    <= ENG_IDLE;
      r_ir     <= IR_IDCODE;
      r_ir_sr  <= '0;
      r_dr     <= '0;
      r_addr   <= '0;
      r_haddr  <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_htrans <= HTRANS_IDLE;
      r_hwrite <= 1'b0;
      r_err    <= 1'b0;
      r_ovr    <= 1'b0;
      r_tdo    <= 1'b0;
    end else begin
      r_tap    <= w_tap_nxt;
      r_eng    <= w_eng_nxt;
      r_ir_sr  <= w_ir_sr_nxt;
      r_dr     <= w_dr_nxt;
      r_tdo    <= w_tdo_nxt;
      r_htrans <= (w_eng_nxt == ENG_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;

      if (r_tap == TAP_TLR)         r_ir <= IR_IDCODE;
      else if (r_tap == TAP_UPD_IR) r_ir <= r_ir_sr;

      if (w_accept) begin
        r_haddr  <= r_addr;
        r_hwrite <= (r_ir == IR_WRITE);
      end
      if (w_start && w_busy) r_ovr <= 1'b1;

      if (w_done) begin
        if (!r_hwrite) r_rdata <= ahb.HRDATA;
`ifdef JTAG_AHB_AUTOINC_EN
        if (!ahb.HRESP) r_addr <= r_addr + ADDR_WIDTH'(BYTES);
`endif
      end

      // Update-DR effects; an explicit address load wins over auto-increment
      if (r_tap == TAP_UPD_DR) begin
        case (r_ir)
          IR_ADDR:   r_addr <= r_dr[ADDR_WIDTH-1:0] & ADDR_MASK;
          IR_WRITE:  if (!w_busy) r_wdata <= r_dr[DATA_WIDTH-1:0];
          IR_STATUS: begin
            if (r_dr[2]) r_err <= 1'b0;
            if (r_dr[1]) r_ovr <= 1'b0;
          end
          default: ;
        endcase
      end

      // A new error response wins over a same-cycle software clear
      if (w_done && ahb.HRESP) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jtag_ahb_dap.sv
// Self-checking bench for jtag_ahb_dap: directed JTAG scans with randomized
// addresses, data, wait states and responses against a register-level model.
module tb_jtag_ahb_dap;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned IRW = 4;

  logic TCK = 1'b0;
  logic TRST, TMS, TDI, TDO;

  jtag_ahb_dap_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ahb ();

  jtag_ahb_dap #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IR_SIZE(IRW), .IDCODE_VAL(32'h1000F00F)
  ) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .ahb(ahb)
  );

  always #5 TCK = ~TCK;

  int n_chk  = 0;
  int n_fail = 0;

  // Architectural model of the software-visible registers
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_err, m_ovr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // From Run-Test/Idle: load IR, return captured IR bits, end in Run-Test/Idle
  task automatic shift_ir(input logic [IRW-1:0] v, output logic [IRW-1:0] o);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < IRW; i++) begin
      o[i] = TDO;
      tick(i == IRW - 1, v[i]);
    end
    tick(1, 0);
    tick(0, 0);
  endtask

  // From Run-Test/Idle: scan len DR bits; returns right after the Update-DR edge
  task automatic shift_dr(input int len, input logic [63:0] v, output logic [63:0] o);
    o = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < len; i++) begin
      o[i] = TDO;
      tick(i == len - 1, v[i]);
    end
    tick(1, 0);
    tick(0, 0);
  endtask

  task automatic set_ir(input int code);
    logic [IRW-1:0] o;
    shift_ir(IRW'(code), o);
  endtask

  // Address phase is visible now; plays the slave for the data phase
  task automatic ahb_xfer(input bit wr, input int waits, input logic [31:0] rd, input bit resp);
    chk("htrans_nonseq", 64'(ahb.HTRANS), 64'(2'b10));
    chk("haddr", 64'(ahb.HADDR), 64'(m_addr));
    chk("hwrite", 64'(ahb.HWRITE), 64'(wr));
    chk("hsize", 64'(ahb.HSIZE), 64'(3'b010));
    ahb.HREADY = 1'b1;
    tick(0, 0);
    chk("htrans_data", 64'(ahb.HTRANS), 64'(0));
    if (wr) chk("hwdata", 64'(ahb.HWDATA), 64'(m_wdata));
    for (int w = 0; w < waits; w++) begin
      ahb.HREADY = 1'b0;
      tick(0, 0);
      chk("htrans_wait", 64'(ahb.HTRANS), 64'(0));
      if (wr) chk("hwdata_hold", 64'(ahb.HWDATA), 64'(m_wdata));
    end
    ahb.HREADY = 1'b1;
    ahb.HRDATA = rd;
    ahb.HRESP  = resp;
    tick(0, 0);
    ahb.HRESP  = 1'b0;
    ahb.HRDATA = $urandom;
    chk("htrans_after", 64'(ahb.HTRANS), 64'(0));
    if (!wr) m_rdata = rd;
    if (resp) m_err = 1'b1;
`ifdef JTAG_AHB_AUTOINC_EN
    if (!resp) m_addr = m_addr + 32'd4;
`endif
  endtask

  task automatic set_addr(input logic [31:0] a);
    logic [63:0] o;
    set_ir(2);
    shift_dr(32, 64'(a), o);
    chk("addr_capture", o, 64'(m_addr));
    m_addr = a & ~32'h3;
  endtask

  task automatic do_write(input logic [31:0] d, input int waits, input bit resp);
    logic [63:0] o;
    set_ir(3);
    shift_dr(32, 64'(d), o);
    chk("wdata_capture", o, 64'(m_wdata));
    m_wdata = d;
    ahb_xfer(1'b1, waits, 32'(0), resp);
  endtask

  task automatic do_read(input logic [31:0] rd, input int waits, input bit resp);
    logic [63:0] o;
    set_ir(4);
    shift_dr(32, 64'($urandom), o);
    chk("rdata_capture", o, 64'(m_rdata));
    ahb_xfer(1'b0, waits, rd, resp);
  endtask

  task automatic check_status(input logic [2:0] clr, input bit busy);
    logic [63:0] o;
    set_ir(5);
    shift_dr(3, 64'(clr), o);
    chk("status", o, 64'({m_err, m_ovr, busy}));
    if (clr[2]) m_err = 1'b0;
    if (clr[1]) m_ovr = 1'b0;
  endtask

  initial begin
    logic [63:0]    o;
    logic [IRW-1:0] irc;
    logic [7:0]     bv;
    logic [31:0]    a, d, stale;

    m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0; m_ovr = 1'b0;
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0;
    ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = '0;

    // 1: reset values and IDCODE scan
    @(posedge TCK); #1;
    @(posedge TCK); #1;
    TRST = 1'b0;
    chk("rst_tdo", 64'(TDO), 64'(0));
    chk("rst_htrans", 64'(ahb.HTRANS), 64'(0));
    chk("rst_hwrite", 64'(ahb.HWRITE), 64'(0));
    chk("rst_haddr", 64'(ahb.HADDR), 64'(0));
    chk("rst_hwdata", 64'(ahb.HWDATA), 64'(0));
    tick(0, 0);
    shift_dr(32, 64'(0), o);
    chk("idcode", o, 64'h1000F00F);
    chk("tdo_idle", 64'(TDO), 64'(0));

    // 2: bypass path and IR capture pattern
    shift_ir(IRW'(4'b1111), irc);
    chk("ir_capture", 64'(irc[1:0]), 64'(2'b01));
    bv = 8'b10110011;
    shift_dr(8, 64'(bv), o);
    chk("bypass", o, 64'({bv[6:0], 1'b0}));

    // Five TMS=1 edges return IR to IDCODE
    for (int i = 0; i < 5; i++) tick(1, 0);
    tick(0, 0);
    shift_dr(32, 64'(0), o);
    chk("tlr_idcode", o, 64'h1000F00F);

    // 3: write with zero wait states, then read back address
    set_addr(32'h20000010);
    do_write(32'hDEADBEEF, 0, 1'b0);
    set_addr($urandom);

    // 4: read with three wait states, then observe the captured data
    do_read(32'h0000F00F, 3, 1'b0);
    do_read($urandom, 0, 1'b0);
    check_status(3'b000, 1'b0);

    // 5: error response is sticky until cleared; no increment on error
    do_write($urandom, 1, 1'b1);
    check_status(3'b100, 1'b0);
    check_status(3'b000, 1'b0);
    set_addr($urandom);

    // Randomized transfers, including the top-of-space address
    for (int k = 0; k < 10; k++) begin
      a = (k == 3) ? 32'hFFFFFFFC : 32'($urandom);
      set_addr(a);
      if ($urandom_range(0, 1) == 1) do_write($urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      else                           do_read($urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      set_addr($urandom);
      check_status(3'($urandom), 1'b0);
    end
    check_status(3'b110, 1'b0);

    // 6: start a read that stalls in its data phase
    set_addr($urandom);
    set_ir(4);
    shift_dr(32, 64'(0), o);
    chk("rdata_capture", o, 64'(m_rdata));
    stale = m_rdata;
    chk("htrans_nonseq", 64'(ahb.HTRANS), 64'(2'b10));
    ahb.HREADY = 1'b1;
    tick(0, 0);
    ahb.HREADY = 1'b0;
    d = $urandom;
    set_ir(3);
    shift_dr(32, 64'(d), o);
    chk("wdata_capture_busy", o, 64'(m_wdata));
    chk("no_second_nonseq", 64'(ahb.HTRANS), 64'(0));
    m_ovr = 1'b1;
    set_ir(4);
    shift_dr(32, 64'(0), o);
    chk("stale_rdata", o, 64'(stale));
    check_status(3'b000, 1'b1);
    set_ir(3);
    shift_dr(32, 64'(0), o);
    chk("wdata_kept", o, 64'(m_wdata));
    chk("htrans_stall", 64'(ahb.HTRANS), 64'(0));

    // Reset in the data phase aborts the transfer
    TRST = 1'b1;
    tick(0, 0);
    TRST = 1'b0;
    ahb.HREADY = 1'b1;
    chk("abort_htrans", 64'(ahb.HTRANS), 64'(0));
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0; m_ovr = 1'b0;
    tick(0, 0);
    chk("abort_htrans2", 64'(ahb.HTRANS), 64'(0));
    shift_dr(32, 64'(0), o);
    chk("rst_idcode", o, 64'h1000F00F);
    check_status(3'b000, 1'b0);
    set_addr($urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
